pair_serial_tx: RTL and testbench



---
 rtl/pair_serial_tx.sv | 128 ++++++++++++
 tb/tb_pair_serial_tx.sv | 115 +++++++++++
 2 files changed

// File: rtl/pair_serial_tx.sv
// Serial frame transmitter: {a, b} word -> start bit, DATA_W data bits LSB first, stop bit(s).
// Latency: start bit on out the cycle after acceptance; frame is (1+DATA_W+STOP_BITS)*CLKS_PER_BIT cycles.
// Backpressure: in_ready is high only in IDLE; in_valid at any other time is ignored and the source holds.
module pair_serial_tx #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W/2-1:0]   a,
    input  logic [DATA_W/2-1:0]   b,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  out,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = $clog2(CLKS_PER_BIT * 2);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cyc_cnt, cyc_nxt;
    logic [BW-1:0]     bit_cnt, bit_nxt;
    logic [DATA_W-1:0] shift_reg, shift_nxt;
    logic              out_nxt, busy_nxt, done_nxt;

    // Gated by rst so a word presented during reset is never accepted.
    assign in_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cyc_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            out       <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cyc_cnt   <= cyc_nxt;
            bit_cnt   <= bit_nxt;
            shift_reg <= shift_nxt;
            out       <= out_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cyc_nxt   = cyc_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift_reg;

        case (state)
            IDLE: begin
                cyc_nxt = '0;
                bit_nxt = '0;
                if (in_valid) begin
                    state_nxt = START;
                    shift_nxt = {a, b};
                end
            end
            START: begin
                if (cyc_cnt == BIT_LAST) begin
                    cyc_nxt   = '0;
                    state_nxt = DATA;
                end else begin
                    cyc_nxt = cyc_cnt + CW'(1);
                end
            end
            DATA: begin
                if (cyc_cnt == BIT_LAST) begin
                    cyc_nxt   = '0;
                    shift_nxt = shift_reg >> 1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_nxt   = '0;
                        state_nxt = STOP;
                    end else begin
                        bit_nxt = bit_cnt + BW'(1);
                    end
                end else begin
                    cyc_nxt = cyc_cnt + CW'(1);
                end
            end
            STOP: begin
                if (cyc_cnt == STOP_LAST) begin
                    cyc_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cyc_nxt = cyc_cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cyc_nxt   = '0;
                bit_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered, so they are derived from the state being entered.
    always_comb begin
        out_nxt  = 1'b1;
        busy_nxt = (state_nxt != IDLE);
        done_nxt = 1'b0;
        case (state_nxt)
            START:   out_nxt = 1'b0;
            DATA:    out_nxt = shift_nxt[0];
            STOP:    done_nxt = (cyc_nxt == STOP_LAST);
            default: out_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_pair_serial_tx.sv
// Bench for pair_serial_tx: cycle table on a CLKS_PER_BIT=2 instance, hand sequence on a CLKS_PER_BIT=1 one.
module tb_pair_serial_tx;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, vld0, rdy0, out0, busy0, done0;
    logic [1:0] a0, b0;
    logic       rst1, vld1, rdy1, out1, busy1, done1;
    logic [1:0] a1, b1;

    pair_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(2), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst0), .a(a0), .b(b0), .in_valid(vld0),
        .in_ready(rdy0), .out(out0), .busy(busy0), .done(done0)
    );

    pair_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst1), .a(a1), .b(b1), .in_valid(vld1),
        .in_ready(rdy1), .out(out1), .busy(busy1), .done(done1)
    );

    // exp packs {out, busy, done, in_ready} for the cycle the inputs are applied in.
    typedef struct {
        logic       rst;
        logic       vld;
        logic [1:0] a;
        logic [1:0] b;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   failures = 0;

    task automatic add(input logic r, input logic v, input logic [1:0] ia,
                       input logic [1:0] ib, input logic [3:0] e);
        vec_t t;
        t.rst = r; t.vld = v; t.a = ia; t.b = ib; t.exp = e;
        tbl.push_back(t);
    endtask

    // Push n busy cycles whose out values are outs[11], outs[10], ...
    task automatic add_frame(input logic v, input logic [1:0] ia, input logic [1:0] ib,
                             input logic [11:0] outs, input int n, input logic with_done);
        for (int i = 0; i < n; i++)
            add(1'b0, v, ia, ib, {outs[11-i], 1'b1, (with_done && i == 11), 1'b0});
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s {out,busy,done,rdy} got=%b want=%b", name, act, exp);
        end
    endtask

    initial begin
        // reset held 3 cycles with in_valid high, then idle
        for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 2'b10, 2'b01, 4'b1000);
        add(1'b0, 1'b0, 2'b00, 2'b00, 4'b1001);
        add(1'b0, 1'b0, 2'b00, 2'b00, 4'b1001);
        // basic frame, word 1001
        add(1'b0, 1'b1, 2'b10, 2'b01, 4'b1001);
        add_frame(1'b0, 2'b00, 2'b00, 12'b001100001111, 12, 1'b1);
        // back-to-back: 1111 then 0000, a/b switch to 0000 during the first frame
        add(1'b0, 1'b1, 2'b11, 2'b11, 4'b1001);
        add_frame(1'b1, 2'b00, 2'b00, 12'b001111111111, 12, 1'b1);
        add(1'b0, 1'b1, 2'b00, 2'b00, 4'b1001);
        add_frame(1'b0, 2'b00, 2'b00, 12'b000000000011, 12, 1'b1);
        // mid-frame reset on the first cycle of data bit 2
        add(1'b0, 1'b1, 2'b10, 2'b01, 4'b1001);
        add_frame(1'b0, 2'b00, 2'b00, 12'b001100001111, 6, 1'b0);
        add(1'b1, 1'b0, 2'b00, 2'b00, 4'b0100);
        add(1'b0, 1'b0, 2'b00, 2'b00, 4'b1001);
        // recovery frame, word 0110
        add(1'b0, 1'b1, 2'b01, 2'b10, 4'b1001);
        add_frame(1'b0, 2'b00, 2'b00, 12'b000011110011, 12, 1'b1);
        add(1'b0, 1'b0, 2'b00, 2'b00, 4'b1001);

        rst0 = 1'b1; vld0 = 1'b1; a0 = 2'b10; b0 = 2'b01;
        rst1 = 1'b1; vld1 = 1'b0; a1 = 2'b00; b1 = 2'b00;
        @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst0 = tbl[i].rst; vld0 = tbl[i].vld; a0 = tbl[i].a; b0 = tbl[i].b;
            #1;
            check($sformatf("cpb2_row%0d", i), {out0, busy0, done0, rdy0}, tbl[i].exp);
        end

        // one cycle per bit, two stop bits, word 0110
        begin
            logic [6:0] pat;
            pat = 7'b0011011;
            @(negedge clk);
            rst1 = 1'b0; vld1 = 1'b0;
            #1 check("cpb1_idle", {out1, busy1, done1, rdy1}, 4'b1001);
            @(negedge clk);
            vld1 = 1'b1; a1 = 2'b01; b1 = 2'b10;
            #1 check("cpb1_accept", {out1, busy1, done1, rdy1}, 4'b1001);
            for (int i = 0; i < 7; i++) begin
                @(negedge clk);
                vld1 = 1'b0; a1 = 2'b00; b1 = 2'b00;
                #1 check($sformatf("cpb1_bit%0d", i), {out1, busy1, done1, rdy1},
                         {pat[6-i], 1'b1, (i == 6), 1'b0});
            end
            @(negedge clk);
            #1 check("cpb1_after", {out1, busy1, done1, rdy1}, 4'b1001);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
